// File: rtl/rom_load_pkg.sv
// ============================================================================
// rom_load_pkg : ROM image region map, FSM state type and address decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package rom_load_pkg;

  localparam logic [24:0] c_reg0_base = 25'h000_0000;
  localparam logic [24:0] c_reg1_base = 25'h000_8000;
  localparam logic [24:0] c_reg2_base = 25'h000_E000;
  localparam logic [24:0] c_reg3_base = 25'h001_0000;
  localparam logic [24:0] c_image_end = 25'h001_8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  sel;
    logic [15:0] offset;
  } region_t;

  function automatic region_t region_decode(input logic [24:0] addr);
    region_t     r;
    logic [24:0] base;
    r.valid = 1'b1;
    r.sel   = 2'd0;
    base    = c_reg0_base;
    if (addr < c_reg1_base) begin
      r.sel = 2'd0;
      base  = c_reg0_base;
    end else if (addr < c_reg2_base) begin
      r.sel = 2'd1;
      base  = c_reg1_base;
    end else if (addr < c_reg3_base) begin
      r.sel = 2'd2;
      base  = c_reg2_base;
    end else if (addr < c_image_end) begin
      r.sel = 2'd3;
      base  = c_reg3_base;
    end else begin
      r.valid = 1'b0;
      base    = addr;
    end
    r.offset = 16'(addr - base);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_load_ctrl.sv
// ============================================================================
// rom_load_ctrl : steers hps_io ROM download bytes onto a req/ack write port
// Rev 1.0
// ============================================================================
`default_nettype none

module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter int         HOLD_CYCLES = 1024,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        core_reset,
  output logic        loaded,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int              HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]      c_ack_last  = 8'(ACK_TIMEOUT);

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dl_prev_q;
  logic              rom_dl_q, rom_dl_d;
  logic              end_pend_q, end_pend_d;
  logic              core_reset_q, core_reset_d;
  logic              loaded_q, loaded_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;

  logic    idx_match, dl_start, dl_end, byte_acc;
  region_t hit;

  assign idx_match = (ioctl_index == ROM_INDEX);
  assign dl_start  = ioctl_download & ~dl_prev_q & idx_match;
  // rom_dl_q remembers that the running download is ours, so the fall is
  // recognised even if hps_io changes the index as it drops download.
  assign dl_end    = rom_dl_q & ~ioctl_download;
  assign byte_acc  = ioctl_download & idx_match & ioctl_wr;
  assign hit       = region_decode(ioctl_addr);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    end_pend_d   = end_pend_q;
    core_reset_d = core_reset_q;
    loaded_d     = loaded_q;
    err_ovf_d    = err_ovf_q;
    err_tmo_d    = err_tmo_q;
    rom_dl_d     = ioctl_download & (rom_dl_q | dl_start);

    if (dl_start) begin
      core_reset_d = 1'b1;
      loaded_d     = 1'b0;
      err_ovf_d    = 1'b0;
      err_tmo_d    = 1'b0;
      end_pend_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (dl_end) begin
          state_d = HOLD;
          hold_d  = '0;
        end else if (byte_acc) begin
          if (hit.valid) begin
            state_d = WRITE;
            sel_d   = hit.sel;
            addr_d  = hit.offset;
            data_d  = ioctl_data;
            tmo_d   = 8'd0;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // An ack landing on the timeout cycle still counts as a good write.
        if (mem_ack || (tmo_q == c_ack_last)) begin
          if (!mem_ack) err_tmo_d = 1'b1;
          if (end_pend_q || dl_end) begin
            state_d    = HOLD;
            hold_d     = '0;
            end_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (dl_end) end_pend_d = 1'b1;
        end
      end
      HOLD: begin
        if (dl_start) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == c_hold_last) begin
          state_d      = IDLE;
          core_reset_d = 1'b0;
          loaded_d     = ~(err_ovf_q | err_tmo_q);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      addr_q       <= 16'd0;
      data_q       <= 8'd0;
      tmo_q        <= 8'd0;
      hold_q       <= '0;
      dl_prev_q    <= 1'b0;
      rom_dl_q     <= 1'b0;
      end_pend_q   <= 1'b0;
      core_reset_q <= 1'b1;
      loaded_q     <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      tmo_q        <= tmo_d;
      hold_q       <= hold_d;
      dl_prev_q    <= ioctl_download;
      rom_dl_q     <= rom_dl_d;
      end_pend_q   <= end_pend_d;
      core_reset_q <= core_reset_d;
      loaded_q     <= loaded_d;
      err_ovf_q    <= err_ovf_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign mem_req      = (state_q == WRITE);
  assign ioctl_wait   = (state_q == WRITE);
  assign mem_sel      = sel_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign core_reset   = core_reset_q;
  assign loaded       = loaded_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_tmo_q;

endmodule

`default_nettype wire

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences HPS ioctl ROM download bytes into the core's ROM regions through a single request/acknowledge memory write port.
- Back-pressures hps_io through ioctl_wait while a byte is outstanding.
- Holds the core in reset during a download and for a fixed period after it.
- Sits between hps_io and the tiamc1 memory banks, clocked by clk_sys.

Parameters:
- ROM_INDEX, 8'd0, ioctl_index value accepted as ROM data; all other indices are ignored.
- HOLD_CYCLES, 1024, number of clk_sys cycles core_reset stays high after download end.
- ACK_TIMEOUT, 255, maximum cycles to wait for mem_ack before dropping the byte.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active (from hps_io).
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address in the ROM image.
- ioctl_data  in  8  byte value.
- ioctl_wait  out  1  stall request to hps_io.
- mem_sel  out  2  target region, 0..3.
- mem_addr  out  16  offset within the region.
- mem_data  out  8  write data.
- mem_req  out  1  write request, level.
- mem_ack  in  1  single-cycle write accept.
- core_reset  out  1  reset to the emulated machine.
- loaded  out  1  a complete download has finished without error.
- err_overflow  out  1  sticky: a byte addressed beyond the last region was seen.
- err_timeout  out  1  sticky: a mem_ack timeout occurred.

Behaviour:
- Reset values: ioctl_wait=0, mem_req=0, mem_sel/mem_addr/mem_data=0, core_reset=1, loaded=0, err_*=0, FSM=IDLE.
- Region map (package constants, contiguous in the image):
  - region 0: 0x00000–0x07FFF
  - region 1: 0x08000–0x0DFFF
  - region 2: 0x0E000–0x0FFFF
  - region 3: 0x10000–0x17FFF
  - mem_addr = ioctl_addr − region base, truncated to 16 bits.
- FSM states: IDLE, WRITE, HOLD.
- IDLE:
  - A byte is accepted when ioctl_download=1, ioctl_index=ROM_INDEX and ioctl_wr=1.
  - On an accepted in-map byte, the next cycle has mem_sel/addr/data latched, mem_req=1, ioctl_wait=1, and the FSM in WRITE.
  - On an accepted byte at ≥0x18000: set err_overflow, no write, no wait, stay in IDLE.
- WRITE:
  - mem_req and ioctl_wait stay high and the address/data outputs stay stable until mem_ack.
  - On the mem_ack cycle, the next cycle has mem_req=0, ioctl_wait=0, and the FSM in IDLE.
  - Timeout counter (8-bit) clears on WRITE entry. When it reaches ACK_TIMEOUT: set err_timeout, drop the byte, leave as on ack.
  - mem_ack and the timeout in the same cycle: ack wins, err_timeout not set.
  - ioctl_wr during WRITE is a protocol violation: ignore it, no state change.
  - mem_ack outside WRITE: ignored.
- Download start: on ioctl_download rising with index=ROM_INDEX, clear loaded, err_overflow and err_timeout; core_reset=1 throughout.
- Download end: on ioctl_download falling with index=ROM_INDEX:
  - If in WRITE, finish that byte first (ack or timeout), then enter HOLD.
  - If in IDLE, enter HOLD the next cycle.
- HOLD:
  - Counter runs 0..HOLD_CYCLES−1 with core_reset=1.
  - On expiry: go to IDLE, core_reset=0, loaded = ~(err_overflow|err_timeout).
  - A new download start during HOLD aborts HOLD and re-enters download handling; the counter clears.
- core_reset = 1 while reset, while a ROM download is active, or in HOLD. After power-up it stays 1 until the first completed download.
- Other-index downloads: ignored; no wait, no effect on core_reset.
- Reset asserted mid-operation: all outputs return to reset values immediately (async). The in-flight byte is abandoned.

Decomposition:
- Package rom_load_pkg:
  - region base/size localparams.
  - state enum {IDLE, WRITE, HOLD}.
  - region-decode function: addr → {valid, sel, offset}.
- Sub-module: none required. The HOLD counter stays inline.

Test Plan:
- Write byte 0xA5 at addr 0x08010 with ack after 3 cycles → mem_sel=1, mem_addr=0x0010, mem_data=0xA5; ioctl_wait high for exactly 4 cycles; one mem_req transaction.
- Stream 0x18000 bytes with zero-latency ack, then drop download → every region receives correct offsets; core_reset stays 1 for HOLD_CYCLES after the fall, then 0; loaded=1.
- Byte at addr 0x18000 → no mem_req, ioctl_wait stays 0, err_overflow=1, loaded=0 after HOLD.
- Withhold mem_ack → mem_req drops after ACK_TIMEOUT cycles, err_timeout=1, ioctl_wait released.
- Download falls during WRITE, ack arrives 5 cycles later → write completes, HOLD starts the cycle after.
- Assert reset during WRITE → ioctl_wait=0, mem_req=0, core_reset=1 in the same cycle; index=1 downloads never stall or touch memory.
